// File: rtl/transfer_tx_scheduler.sv
// rtl/transfer_tx_scheduler.sv - round-robin byte scheduler feeding the active_transfer start/data channel
module transfer_tx_scheduler #(
   parameter int         N_REQ      = 3,
   parameter int         GAP_CYCLES = 16,
   parameter int         HDR_EN     = 1,
   parameter logic [4:0] HDR_TAG    = 5'b10100
) (
   input  logic                 CLK_66,
   input  logic                 RST,
   input  logic                 enable,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [8*N_REQ-1:0]   req_data,
   output logic [N_REQ-1:0]     req_ready,
   output logic                 start_transfer,
   output logic [7:0]           transfer_to_host,
   output logic [2:0]           grant_id,
   output logic                 busy,
   output logic [15:0]          frame_count
);

   localparam int              IW       = $clog2(N_REQ);
   localparam int              CW       = $clog2(GAP_CYCLES + 1);
   localparam logic [IW:0]     NQ       = (IW+1)'(N_REQ);
   localparam logic [CW-1:0]   GAP_LOAD = CW'(GAP_CYCLES);

   typedef enum logic [2:0] {S_IDLE, S_HDR, S_HGAP, S_DATA, S_DGAP} state_t;

   state_t            state_q, state_d;
   logic [N_REQ-1:0]  full_q;
   logic [7:0]        slot_q [N_REQ];
   logic [IW-1:0]     rr_q, grant_q, grant_d, winner;
   logic              any_full, launch;
   logic [CW-1:0]     gap_q;
   logic [15:0]       frame_q;
   logic [7:0]        tth_q;

   function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] base, input logic [IW:0] step);
      logic [IW:0] s;
      s = {1'b0, base} + step;
      if (s >= NQ)
         s = s - NQ;
      return s[IW-1:0];
   endfunction

   // Scan downward so the full slot closest to the RR pointer is the last (winning) assignment.
   always_comb begin
      any_full = 1'b0;
      winner   = rr_q;
      for (int k = N_REQ-1; k >= 0; k--) begin
         if (full_q[wrap_inc(rr_q, (IW+1)'(k))]) begin
            any_full = 1'b1;
            winner   = wrap_inc(rr_q, (IW+1)'(k));
         end
      end
   end

   assign launch  = (state_q == S_IDLE) && enable && any_full;
   assign grant_d = launch ? winner : grant_q;

   always_ff @(posedge CLK_66 or negedge RST) begin
      if (!RST)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (launch) state_d = (HDR_EN != 0) ? S_HDR : S_DATA;
         S_HDR:  state_d = S_HGAP;
         S_HGAP: if (gap_q <= CW'(1)) state_d = S_DATA;
         S_DATA: state_d = S_DGAP;
         S_DGAP: if (gap_q <= CW'(1)) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      start_transfer = (state_q == S_HDR) || (state_q == S_DATA);
      busy           = (state_q != S_IDLE);
   end

   // The byte register is loaded on entry to HDR/DATA so it is valid during the pulse and held afterwards.
   always_ff @(posedge CLK_66 or negedge RST) begin
      if (!RST) begin
         grant_q <= '0;
         rr_q    <= '0;
         frame_q <= '0;
         gap_q   <= '0;
         tth_q   <= 8'h00;
      end else begin
         grant_q <= grant_d;
         if (state_d == S_HDR && state_q != S_HDR)
            tth_q <= {HDR_TAG, 3'(grant_d)};
         else if (state_d == S_DATA && state_q != S_DATA)
            tth_q <= slot_q[grant_d];
         case (state_q)
            S_HDR: gap_q <= GAP_LOAD;
            S_DATA: begin
               gap_q   <= GAP_LOAD;
               rr_q    <= wrap_inc(grant_q, (IW+1)'(1));
               frame_q <= frame_q + 16'd1;
            end
            S_HGAP, S_DGAP: if (gap_q != '0) gap_q <= gap_q - CW'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK_66 or negedge RST) begin
      if (!RST)
         full_q <= '0;
      else begin
         for (int i = 0; i < N_REQ; i++) begin
            if (state_q == S_DATA && grant_q == IW'(i))
               full_q[i] <= 1'b0;
            else if (req_valid[i] && !full_q[i])
               full_q[i] <= 1'b1;
         end
      end
   end

   always_ff @(posedge CLK_66) begin
      for (int i = 0; i < N_REQ; i++) begin
         if (req_valid[i] && !full_q[i])
            slot_q[i] <= req_data[8*i +: 8];
      end
   end

   assign req_ready        = ~full_q;
   assign transfer_to_host = tth_q;
   assign grant_id         = 3'(grant_q);
   assign frame_count      = frame_q;

endmodule

// File: tb/tb_transfer_tx_scheduler.sv
// tb/tb_transfer_tx_scheduler.sv - randomized self-checking bench for transfer_tx_scheduler
module tb_transfer_tx_scheduler;

   logic        CLK_66 = 1'b0;
   logic        RST = 1'b0;
   logic        enable = 1'b1;
   logic [2:0]  req_valid = '0;
   logic [23:0] req_data = '0;
   logic [2:0]  rdy_a, rdy_b, gid_a, gid_b;
   logic        st_a, st_b, busy_a, busy_b;
   logic [7:0]  tth_a, tth_b;
   logic [15:0] fc_a, fc_b;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int m_rr = 0;
   int m_fc = 0;
   logic [7:0] pb_a[$], pb_b[$];
   int         pc_a[$], pc_b[$];

   transfer_tx_scheduler dut_a (
      .CLK_66(CLK_66), .RST(RST), .enable(enable), .req_valid(req_valid), .req_data(req_data),
      .req_ready(rdy_a), .start_transfer(st_a), .transfer_to_host(tth_a), .grant_id(gid_a),
      .busy(busy_a), .frame_count(fc_a));

   transfer_tx_scheduler #(.GAP_CYCLES(1), .HDR_EN(0)) dut_b (
      .CLK_66(CLK_66), .RST(RST), .enable(enable), .req_valid(req_valid), .req_data(req_data),
      .req_ready(rdy_b), .start_transfer(st_b), .transfer_to_host(tth_b), .grant_id(gid_b),
      .busy(busy_b), .frame_count(fc_b));

   always #5 CLK_66 = ~CLK_66;
   always @(posedge CLK_66) cyc++;

   always @(negedge CLK_66) begin
      if (st_a) begin pb_a.push_back(tth_a); pc_a.push_back(cyc); end
      if (st_b) begin pb_b.push_back(tth_b); pc_b.push_back(cyc); end
   end

   task automatic send(input bit sel, input int i, input logic [7:0] b, output int acc);
      int n;
      n = 0;
      @(negedge CLK_66);
      req_valid[i] = 1'b1;
      req_data[8*i +: 8] = b;
      while (!(sel ? rdy_b[i] : rdy_a[i]) && n < 2000) begin
         @(negedge CLK_66);
         n++;
      end
      total++;
      if (n >= 2000) begin bad++; $display("FAIL send_ready req%0d: waited=%0d limit=2000", i, n); end
      acc = cyc;
      @(negedge CLK_66);
      req_valid[i] = 1'b0;
   endtask

   task automatic wait_pulses(input bit sel, input int n);
      int k;
      k = 0;
      while ((sel ? pb_b.size() : pb_a.size()) < n && k < 2000) begin
         @(posedge CLK_66);
         k++;
      end
      total++;
      if ((sel ? pb_b.size() : pb_a.size()) < n) begin
         bad++;
         $display("FAIL pulse_wait dut%0d: got=%0d want=%0d", sel, sel ? pb_b.size() : pb_a.size(), n);
      end
   endtask

   task automatic wait_idle(input bit sel);
      int k;
      k = 0;
      do begin
         @(negedge CLK_66);
         k++;
      end while (((sel ? busy_b : busy_a) || (sel ? rdy_b : rdy_a) != 3'b111) && k < 2000);
      total++;
      if (k >= 2000) begin bad++; $display("FAIL idle_wait dut%0d: still busy after %0d cycles", sel, k); end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge CLK_66);
      total++; if (rdy_a !== 3'b111) begin bad++; $display("FAIL rst_ready: got %b want 111", rdy_a); end
      total++; if (st_a !== 1'b0) begin bad++; $display("FAIL rst_start: got %b want 0", st_a); end
      total++; if (tth_a !== 8'h00) begin bad++; $display("FAIL rst_tth: got %h want 00", tth_a); end
      total++; if (gid_a !== 3'd0) begin bad++; $display("FAIL rst_gid: got %0d want 0", gid_a); end
      total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy_a); end
      total++; if (fc_a !== 16'd0) begin bad++; $display("FAIL rst_fc: got %0d want 0", fc_a); end
      RST = 1'b1;
      m_rr = 0;
      m_fc = 0;
   endtask

   task automatic test_single();
      int acc;
      pb_a.delete(); pc_a.delete();
      send(0, 1, 8'h3C, acc);
      wait_pulses(0, 2);
      total++; if (pb_a[0] !== 8'hA1) begin bad++; $display("FAIL single_hdr: got %h want a1", pb_a[0]); end
      total++; if (pb_a[1] !== 8'h3C) begin bad++; $display("FAIL single_data: got %h want 3c", pb_a[1]); end
      total++; if (pc_a[0] - acc != 2) begin bad++; $display("FAIL single_latency: got %0d want 2", pc_a[0] - acc); end
      total++; if (pc_a[1] - pc_a[0] != 17) begin bad++; $display("FAIL single_gap: got %0d want 17", pc_a[1] - pc_a[0]); end
      @(negedge CLK_66);
      total++; if (rdy_a[1] !== 1'b1) begin bad++; $display("FAIL single_ready: got %b want 1", rdy_a[1]); end
      total++; if (fc_a !== 16'd1) begin bad++; $display("FAIL single_fc: got %0d want 1", fc_a); end
      total++; if (gid_a !== 3'd1) begin bad++; $display("FAIL single_gid: got %0d want 1", gid_a); end
      m_rr = 2;
      m_fc = 1;
      wait_idle(0);
   endtask

   task automatic test_round_robin();
      RST = 1'b0;
      repeat (3) @(negedge CLK_66);
      RST = 1'b1;
      m_rr = 0;
      m_fc = 0;
      for (int it = 0; it < 6; it++) begin
         logic [2:0] mask;
         logic [7:0] bv [3];
         int exp_id[$];
         mask = (it == 0) ? 3'b111 : 3'($urandom_range(1, 7));
         for (int k = 0; k < 3; k++) bv[k] = (it == 0) ? 8'((k + 1) * 16) : 8'($urandom);
         for (int k = 0; k < 3; k++) if (mask[(m_rr + k) % 3]) exp_id.push_back((m_rr + k) % 3);
         m_rr = (exp_id[exp_id.size() - 1] + 1) % 3;
         m_fc += exp_id.size();
         pb_a.delete(); pc_a.delete();
         @(negedge CLK_66);
         req_valid = mask;
         req_data = {bv[2], bv[1], bv[0]};
         @(negedge CLK_66);
         req_valid = '0;
         wait_pulses(0, 2 * exp_id.size());
         for (int j = 0; j < exp_id.size(); j++) begin
            total++;
            if (pb_a[2*j] !== (8'hA0 | 8'(exp_id[j]))) begin
               bad++; $display("FAIL rr_hdr it%0d f%0d: got %h want %h", it, j, pb_a[2*j], 8'hA0 | 8'(exp_id[j]));
            end
            total++;
            if (pb_a[2*j+1] !== bv[exp_id[j]]) begin
               bad++; $display("FAIL rr_data it%0d f%0d: got %h want %h", it, j, pb_a[2*j+1], bv[exp_id[j]]);
            end
            total++;
            if (pc_a[2*j+1] - pc_a[2*j] != 17) begin
               bad++; $display("FAIL rr_gap it%0d f%0d: got %0d want 17", it, j, pc_a[2*j+1] - pc_a[2*j]);
            end
            if (j > 0) begin
               total++;
               if (pc_a[2*j] - pc_a[2*j-1] != 18) begin
                  bad++; $display("FAIL rr_interframe it%0d f%0d: got %0d want 18", it, j, pc_a[2*j] - pc_a[2*j-1]);
               end
            end
         end
         wait_idle(0);
         total++;
         if (fc_a !== 16'(m_fc)) begin bad++; $display("FAIL rr_fc it%0d: got %0d want %0d", it, fc_a, m_fc); end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] b0, b1, b2, c;
      logic [7:0] exp_b [4];
      int exp_g [4];
      b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom); c = 8'($urandom);
      exp_g = '{2, 0, 2, 2};
      exp_b = '{b0, c, b1, b2};
      pb_a.delete(); pc_a.delete();
      fork
         begin
            int a;
            send(0, 2, b0, a);
            send(0, 2, b1, a);
            send(0, 2, b2, a);
         end
         begin
            int a;
            int k;
            k = 0;
            while (pb_a.size() < 1 && k < 2000) begin @(posedge CLK_66); k++; end
            send(0, 0, c, a);
         end
      join
      wait_pulses(0, 8);
      for (int j = 0; j < 4; j++) begin
         total++;
         if (pb_a[2*j] !== (8'hA0 | 8'(exp_g[j]))) begin
            bad++; $display("FAIL b2b_hdr f%0d: got %h want %h", j, pb_a[2*j], 8'hA0 | 8'(exp_g[j]));
         end
         total++;
         if (pb_a[2*j+1] !== exp_b[j]) begin
            bad++; $display("FAIL b2b_data f%0d: got %h want %h", j, pb_a[2*j+1], exp_b[j]);
         end
      end
      m_rr = 0;
      m_fc += 4;
      wait_idle(0);
      total++; if (fc_a !== 16'(m_fc)) begin bad++; $display("FAIL b2b_fc: got %0d want %0d", fc_a, m_fc); end
   endtask

   task automatic test_enable_drop();
      logic [7:0] x, y;
      int a;
      x = 8'($urandom); y = 8'($urandom);
      pb_a.delete(); pc_a.delete();
      send(0, 0, x, a);
      wait_pulses(0, 1);
      @(negedge CLK_66);
      enable = 1'b0;
      send(0, 1, y, a);
      wait_pulses(0, 2);
      total++; if (pb_a[1] !== x) begin bad++; $display("FAIL endrop_data: got %h want %h", pb_a[1], x); end
      repeat (60) @(negedge CLK_66);
      total++; if (pb_a.size() != 2) begin bad++; $display("FAIL endrop_hold: pulses=%0d want 2", pb_a.size()); end
      total++; if (rdy_a[1] !== 1'b0) begin bad++; $display("FAIL endrop_retain: ready=%b want 0", rdy_a[1]); end
      total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL endrop_busy: got %b want 0", busy_a); end
      enable = 1'b1;
      wait_pulses(0, 4);
      total++; if (pb_a[2] !== 8'hA1) begin bad++; $display("FAIL endrop_hdr2: got %h want a1", pb_a[2]); end
      total++; if (pb_a[3] !== y) begin bad++; $display("FAIL endrop_data2: got %h want %h", pb_a[3], y); end
      m_rr = 2;
      m_fc += 2;
      wait_idle(0);
      total++; if (fc_a !== 16'(m_fc)) begin bad++; $display("FAIL endrop_fc: got %0d want %0d", fc_a, m_fc); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] r, z;
      int a;
      r = 8'($urandom); z = 8'($urandom);
      pb_a.delete(); pc_a.delete();
      send(0, 2, r, a);
      wait_pulses(0, 1);
      repeat (3) @(negedge CLK_66);
      RST = 1'b0;
      #1;
      total++; if (st_a !== 1'b0) begin bad++; $display("FAIL rmid_start: got %b want 0", st_a); end
      total++; if (rdy_a !== 3'b111) begin bad++; $display("FAIL rmid_ready: got %b want 111", rdy_a); end
      total++; if (fc_a !== 16'd0) begin bad++; $display("FAIL rmid_fc: got %0d want 0", fc_a); end
      total++; if (busy_a !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %b want 0", busy_a); end
      total++; if (tth_a !== 8'h00) begin bad++; $display("FAIL rmid_tth: got %h want 00", tth_a); end
      repeat (8) @(negedge CLK_66);
      total++; if (pb_a.size() != 1) begin bad++; $display("FAIL rmid_nopulse: pulses=%0d want 1", pb_a.size()); end
      RST = 1'b1;
      m_rr = 0;
      m_fc = 0;
      send(0, 1, z, a);
      wait_pulses(0, 3);
      total++; if (pb_a[1] !== 8'hA1) begin bad++; $display("FAIL rmid_hdr: got %h want a1", pb_a[1]); end
      total++; if (pb_a[2] !== z) begin bad++; $display("FAIL rmid_data: got %h want %h", pb_a[2], z); end
      wait_idle(0);
      m_fc = 1;
      m_rr = 2;
      total++; if (fc_a !== 16'(m_fc)) begin bad++; $display("FAIL rmid_fc2: got %0d want %0d", fc_a, m_fc); end
   endtask

   task automatic test_nohdr_wrap();
      int a1, a2;
      wait_idle(1);
      force dut_b.frame_q = 16'hFFFE;
      #1;
      release dut_b.frame_q;
      pb_b.delete(); pc_b.delete();
      send(1, 0, 8'hFF, a1);
      wait_pulses(1, 1);
      #1;
      total++; if (pb_b[0] !== 8'hFF) begin bad++; $display("FAIL nohdr_data1: got %h want ff", pb_b[0]); end
      total++; if (pc_b[0] - a1 != 2) begin bad++; $display("FAIL nohdr_latency: got %0d want 2", pc_b[0] - a1); end
      total++; if (fc_b !== 16'hFFFF) begin bad++; $display("FAIL nohdr_fc1: got %h want ffff", fc_b); end
      total++; if (gid_b !== 3'd0) begin bad++; $display("FAIL nohdr_gid: got %0d want 0", gid_b); end
      send(1, 0, 8'hFF, a2);
      wait_pulses(1, 2);
      #1;
      total++; if (pb_b.size() != 2) begin bad++; $display("FAIL nohdr_count: got %0d want 2", pb_b.size()); end
      total++; if (pb_b[1] !== 8'hFF) begin bad++; $display("FAIL nohdr_data2: got %h want ff", pb_b[1]); end
      total++; if (pc_b[1] - pc_b[0] != 3) begin bad++; $display("FAIL nohdr_spacing: got %0d want 3", pc_b[1] - pc_b[0]); end
      total++; if (fc_b !== 16'h0000) begin bad++; $display("FAIL nohdr_wrap: got %h want 0000", fc_b); end
      @(negedge CLK_66);
      total++; if (busy_b !== 1'b1 || st_b !== 1'b0) begin bad++; $display("FAIL nohdr_dgap: busy=%b start=%b want 1/0", busy_b, st_b); end
      @(negedge CLK_66);
      total++; if (busy_b !== 1'b0) begin bad++; $display("FAIL nohdr_idle: busy=%b want 0", busy_b); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_back_to_back();
      test_enable_drop();
      test_reset_mid();
      test_nohdr_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/transfer_tx_scheduler.md
Name: transfer_tx_scheduler

Overview:
- Shares the single host-bound active_transfer channel (start_transfer / transfer_to_host) among N_REQ byte producers, such as the Arduino write path, the switch-event logger and the status reporter.
- Each requester has a 1-deep holding slot. The scheduler grants slots round-robin, optionally prefixes each data byte with a source-ID header byte, and enforces a minimum idle gap between start pulses so the transfer library is never overrun.
- Sits between the user logic and the active_transfer instance, in the CLK_66 domain.

Parameters:
- N_REQ, 3: number of requesters; legal range 2..8.
- GAP_CYCLES, 16: CLK_66 cycles start_transfer must stay low after every pulse; legal minimum 1.
- HDR_EN, 1: 1 = send a header byte before each data byte; 0 = data byte only.
- HDR_TAG, 5'b10100: upper 5 bits of the header byte.

Ports:
- CLK_66 input 1: system clock.
- RST input 1: reset, asynchronous, active-low.
- enable input 1: 1 = new frames may be granted; 0 = no new grants.
- req_valid input N_REQ: requester i has a byte to send.
- req_data input 8*N_REQ: byte of requester i, at bits [8i+7:8i].
- req_ready output N_REQ: slot i is empty; a byte is accepted when req_valid[i] & req_ready[i].
- start_transfer output 1: one-cycle pulse to active_transfer.
- transfer_to_host output 8: byte presented to active_transfer.
- grant_id output 3: requester currently being served.
- busy output 1: a frame is in progress (FSM not in IDLE).
- frame_count output 16: completed frames; wraps at 16'hFFFF -> 0.

Behaviour:
- Reset values (RST low, async): all slots empty, so req_ready = all 1s. start_transfer=0, transfer_to_host=8'h00, grant_id=0, busy=0, frame_count=0, RR pointer=0, FSM=IDLE, gap counter=0.
- Accept: on an edge where req_valid[i] & req_ready[i], slot i captures req_data[i]. req_ready[i] goes 0 from the next cycle.
- Slot full: req_ready[i]=0. req_valid is ignored; nothing is dropped and the requester must hold its byte.
- FSM states: IDLE, HDR, HGAP, DATA, DGAP.
- IDLE:
  - If enable=1 and any slot is full, pick the first full slot searching from the RR pointer upward with wrap at N_REQ-1 -> 0.
  - Latch grant_id = winner.
  - Next state is HDR if HDR_EN=1, otherwise DATA.
- HDR (one cycle): start_transfer=1, transfer_to_host = {HDR_TAG, grant_id}. Load gap counter with GAP_CYCLES, then go to HGAP.
- HGAP: start_transfer=0. Decrement the counter; when it reaches 0, go to DATA. Total low cycles = GAP_CYCLES exactly.
- DATA (one cycle):
  - start_transfer=1, transfer_to_host = slot[grant_id].
  - Clear slot[grant_id], so req_ready goes 1 next cycle.
  - RR pointer = grant_id+1, wrapping to 0 past N_REQ-1.
  - frame_count increments.
  - Load gap counter, then go to DGAP.
- DGAP: same gap rule as HGAP, then return to IDLE.
- transfer_to_host holds its value between pulses and changes only in HDR/DATA cycles.
- Latency, HDR_EN=1 and idle FSM:
  - Byte accepted at edge E0.
  - Header pulse is the cycle after E1.
  - Data pulse follows GAP_CYCLES later.
  - Next header follows at least GAP_CYCLES+1 cycles after the data pulse.
- Simultaneous events:
  - Accepting into a slot in the same cycle the arbiter samples it counts as not full for that cycle.
  - Slot clear in DATA takes priority; a new byte for the same slot is accepted no earlier than the following edge.
- enable=0 mid-frame: the current frame completes through DGAP. No new grant is made while enable=0. Full slots are retained.
- Reset mid-frame: async clear to the reset values above. A partially sent frame is abandoned and no further pulse is issued.
- busy=1 in every state except IDLE.

Test Plan:
- Req 1 only, byte 8'h3C, defaults -> header pulse 8'hA1, then 16 cycles low, then data pulse 8'h3C. frame_count=1; req_ready[1] returns to 1 after the data pulse.
- Req 0,1,2 valid on the same edge with bytes 8'h10/8'h20/8'h30 -> data order 10,20,30, headers A0,A1,A2. RR pointer ends at 0; no pulse spacing is under 16 cycles.
- Req 2 keeps its slot full back-to-back while req 0 sends once -> grants alternate 2,0,2 (round-robin fairness; no starvation).
- Drop enable during the HGAP of a frame with req 1 pending -> that frame's data pulse still occurs. No further header appears until enable=1; the req 1 byte is then sent intact.
- Assert RST low during HGAP -> start_transfer stays 0, all req_ready=1, frame_count=0. After release, a new request yields a full header+data frame.
- HDR_EN=0, GAP_CYCLES=1, req 0 sends 8'hFF twice -> data-only pulses with exactly 1 low cycle before IDLE. frame_count wraps correctly when preloaded near 16'hFFFF via long run.
